// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline, with saturating event counters.
// Optional build macro HAZARD_R0_GUARD_EN: register $0 never matches, so it never forwards and never stalls.
module hazard_unit #(
    parameter int REG_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemToRegE,
    input  logic             MemToRegM,
    input  logic             BranchD,
    output logic             StallF,
    output logic             StallD,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FwdCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
`ifdef HAZARD_R0_GUARD_EN
        return (a == b) && (a != {REG_W{1'b0}});
`else
        return (a == b);
`endif
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input logic rw_m, input logic [REG_W-1:0] wr_m,
                                           input logic rw_w, input logic [REG_W-1:0] wr_w);
        if (rw_m && reg_match(src, wr_m)) begin
            return 2'b10;
        end else if (rw_w && reg_match(src, wr_w)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    logic       lwstall_s;
    logic       branchstall_s;
    logic       stall_s;
    logic       fwd_any_s;
    logic [1:0] fwd_ae_s;
    logic [1:0] fwd_be_s;
    logic       fwd_ad_s;
    logic       fwd_bd_s;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;

    // Hazard decode; reset forces every hazard output low without waiting for a clock edge.
    always_comb begin
        lwstall_s     = 1'b0;
        branchstall_s = 1'b0;
        fwd_ae_s      = 2'b00;
        fwd_be_s      = 2'b00;
        fwd_ad_s      = 1'b0;
        fwd_bd_s      = 1'b0;
        if (!reset) begin
            fwd_ae_s      = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
            fwd_be_s      = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
            fwd_ad_s      = RegWriteM && reg_match(RsD, WriteRegM);
            fwd_bd_s      = RegWriteM && reg_match(RtD, WriteRegM);
            lwstall_s     = MemToRegE && (reg_match(RsD, RtE) || reg_match(RtD, RtE));
            branchstall_s = BranchD &&
                            ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                             (MemToRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
        end else begin
            lwstall_s     = 1'b0;
            branchstall_s = 1'b0;
        end
        stall_s   = lwstall_s || branchstall_s;
        fwd_any_s = (fwd_ae_s != 2'b00) || (fwd_be_s != 2'b00) || fwd_ad_s || fwd_bd_s;
    end

    // Saturating next-state for both event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (fwd_any_s && (fwd_cnt_q != CNT_MAX)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_ONE;
        end else begin
            fwd_cnt_d = fwd_cnt_q;
        end
    end

    // Counter registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            fwd_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign StallF     = stall_s;
    assign StallD     = stall_s;
    assign FlushE     = stall_s;
    assign ForwardAE  = fwd_ae_s;
    assign ForwardBE  = fwd_be_s;
    assign ForwardAD  = fwd_ad_s;
    assign ForwardBD  = fwd_bd_s;
    assign StallCount = stall_cnt_q;
    assign FwdCount   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; a second instance with CNT_W=2 exercises counter saturation.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, BranchD;
    logic       StallF, StallD, ForwardAD, ForwardBD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic [15:0] StallCount, FwdCount;
    logic       s_StallF, s_StallD, s_ForwardAD, s_ForwardBD, s_FlushE;
    logic [1:0] s_ForwardAE, s_ForwardBE;
    logic [1:0] s_StallCount, s_FwdCount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_W(6), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .BranchD(BranchD),
        .StallF(StallF), .StallD(StallD), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount), .FwdCount(FwdCount)
    );

    hazard_unit #(.REG_W(6), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .BranchD(BranchD),
        .StallF(s_StallF), .StallD(s_StallD), .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
        .FlushE(s_FlushE), .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .StallCount(s_StallCount), .FwdCount(s_FwdCount)
    );

    task automatic clear_inputs();
        RsD = 6'd0; RtD = 6'd0; RsE = 6'd0; RtE = 6'd0;
        WriteRegE = 6'd0; WriteRegM = 6'd0; WriteRegW = 6'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemToRegE = 1'b0; MemToRegM = 1'b0; BranchD = 1'b0;
    endtask

    // Packs {StallF,StallD,FlushE,ForwardAD,ForwardBD,ForwardAE,ForwardBE} for compact comparison.
    function automatic logic [8:0] haz_vec();
        return {StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE};
    endfunction

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        RegWriteM = 1'b1; MemToRegE = 1'b1;
        @(negedge clk); @(negedge clk);
        total++;
        if (haz_vec() !== 9'b0) begin
            bad++; $display("FAIL reset_outputs: got %b expected %b", haz_vec(), 9'b0);
        end
        total++;
        if (StallCount !== 16'd0 || FwdCount !== 16'd0) begin
            bad++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", StallCount, FwdCount);
        end
        clear_inputs();
    endtask

    task automatic test_zero_compare();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        #1;
        total++;
        if (haz_vec() !== 9'b0) begin
            bad++; $display("FAIL all_zero: got %b expected %b", haz_vec(), 9'b0);
        end
        RegWriteM = 1'b1;
        #1;
        total++;
`ifdef HAZARD_R0_GUARD_EN
        if (haz_vec() !== 9'b0) begin
            bad++; $display("FAIL r0_guard: got %b expected %b", haz_vec(), 9'b0);
        end
`else
        if (haz_vec() !== 9'b000_11_10_10) begin
            bad++; $display("FAIL r0_match: got %b expected %b", haz_vec(), 9'b000_11_10_10);
        end
`endif
        clear_inputs();
    endtask

    task automatic test_forward_e();
        @(negedge clk);
        RsE = 6'd5; WriteRegM = 6'd5; RegWriteM = 1'b1; WriteRegW = 6'd5; RegWriteW = 1'b1;
        RsD = 6'd1; RtD = 6'd2; RtE = 6'd6;
        #1;
        total++;
        if (ForwardAE !== 2'b10) begin
            bad++; $display("FAIL fwd_ae_m_priority: got %b expected 10", ForwardAE);
        end
        total++;
        if (ForwardBE !== 2'b00) begin
            bad++; $display("FAIL fwd_be_none: got %b expected 00", ForwardBE);
        end
        WriteRegM = 6'd7;
        #1;
        total++;
        if (ForwardAE !== 2'b01) begin
            bad++; $display("FAIL fwd_ae_w: got %b expected 01", ForwardAE);
        end
        RtE = 6'd7;
        #1;
        total++;
        if (ForwardBE !== 2'b10) begin
            bad++; $display("FAIL fwd_be_m: got %b expected 10", ForwardBE);
        end
        clear_inputs();
    endtask

    task automatic test_forward_d();
        @(negedge clk);
        RsD = 6'd12; RtD = 6'd13; WriteRegM = 6'd13; RegWriteM = 1'b1; RsE = 6'd1; RtE = 6'd2;
        #1;
        total++;
        if ({ForwardAD, ForwardBD} !== 2'b01) begin
            bad++; $display("FAIL fwd_bd: got %b expected 01", {ForwardAD, ForwardBD});
        end
        RegWriteM = 1'b0;
        #1;
        total++;
        if ({ForwardAD, ForwardBD} !== 2'b00) begin
            bad++; $display("FAIL fwd_d_no_write: got %b expected 00", {ForwardAD, ForwardBD});
        end
        clear_inputs();
    endtask

    task automatic test_lwstall();
        @(negedge clk);
        MemToRegE = 1'b1; RtE = 6'd3; RsD = 6'd3; RtD = 6'd8;
        #1;
        total++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            bad++; $display("FAIL lwstall_rs: got %b expected 111", {StallF, StallD, FlushE});
        end
        RsD = 6'd4; RtD = 6'd4;
        #1;
        total++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            bad++; $display("FAIL lwstall_none: got %b expected 000", {StallF, StallD, FlushE});
        end
        RtD = 6'd3;
        #1;
        total++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            bad++; $display("FAIL lwstall_rt: got %b expected 111", {StallF, StallD, FlushE});
        end
        clear_inputs();
    endtask

    task automatic test_branchstall();
        @(negedge clk);
        BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 6'd9; RtD = 6'd9; RsD = 6'd2;
        #1;
        total++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            bad++; $display("FAIL branch_e: got %b expected 111", {StallF, StallD, FlushE});
        end
        BranchD = 1'b0; MemToRegM = 1'b1; WriteRegM = 6'd9;
        #1;
        total++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            bad++; $display("FAIL branch_off: got %b expected 000", {StallF, StallD, FlushE});
        end
        BranchD = 1'b1; RegWriteE = 1'b0;
        #1;
        total++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            bad++; $display("FAIL branch_m_load: got %b expected 111", {StallF, StallD, FlushE});
        end
        clear_inputs();
    endtask

    task automatic test_counters();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        MemToRegE = 1'b1; RtE = 6'd3; RsD = 6'd3; RtD = 6'd8; RsE = 6'd1;
        repeat (3) @(negedge clk);
        total++;
        if (StallCount !== 16'd3 || FwdCount !== 16'd0) begin
            bad++; $display("FAIL stall_count3: got %0d/%0d expected 3/0", StallCount, FwdCount);
        end
        repeat (2) @(negedge clk);
        total++;
        if (StallCount !== 16'd5 || s_StallCount !== 2'd3) begin
            bad++; $display("FAIL saturate: got %0d/%0d expected 5/3", StallCount, s_StallCount);
        end
        clear_inputs();
        RsE = 6'd5; WriteRegM = 6'd5; RegWriteM = 1'b1; RsD = 6'd1; RtD = 6'd2; RtE = 6'd3;
        repeat (2) @(negedge clk);
        total++;
        if (FwdCount !== 16'd2 || StallCount !== 16'd5) begin
            bad++; $display("FAIL fwd_count: got %0d/%0d expected 2/5", FwdCount, StallCount);
        end
        clear_inputs();
        MemToRegE = 1'b1; RtE = 6'd3; RsD = 6'd3;
        reset = 1'b1;
        #1;
        total++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            bad++; $display("FAIL reset_mid_stall: got %b expected 000", {StallF, StallD, FlushE});
        end
        @(negedge clk);
        total++;
        if (StallCount !== 16'd0 || FwdCount !== 16'd0 || s_StallCount !== 2'd0) begin
            bad++; $display("FAIL reset_clear: got %0d/%0d/%0d expected 0/0/0", StallCount, FwdCount, s_StallCount);
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_zero_compare();
        test_forward_e();
        test_forward_d();
        test_lwstall();
        test_branchstall();
        test_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
